// File: rtl/bids22_pkg.sv
// Shared types and constants for the bids22 controller-side sequencer.
//   op_e      : 4-bit auctioneer controller opcodes (NoOp..BidCharge)
//   winner_e  : encoding of the reported round winner
//   Fault*    : fault codes raised by the sequencer itself
//   state_e   : sequencer FSM states
//   load_op   : opcode issued at a given step of the LOAD phase
package bids22_pkg;

  typedef enum logic [3:0] {
    OpNoOp      = 4'd0,
    OpUnlock    = 4'd1,
    OpLock      = 4'd2,
    OpLoadX     = 4'd3,
    OpLoadY     = 4'd4,
    OpLoadZ     = 4'd5,
    OpSetMask   = 4'd6,
    OpSetTimer  = 4'd7,
    OpBidCharge = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    WinNone = 2'd0,
    WinX    = 2'd1,
    WinY    = 2'd2,
    WinZ    = 2'd3
  } winner_e;

  localparam logic [2:0] FaultReadyLost = 3'b110;
  localparam logic [2:0] FaultRoTimeout = 3'b111;

  // Step value at which the last LOAD opcode (BidCharge) is on the bus.
  localparam logic [2:0] LoadLastStep = 3'd6;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StLock,
    StRun,
    StWaitRo,
    StGap,
    StUnlock,
    StDone,
    StFault
  } state_e;

  function automatic op_e load_op(input logic [2:0] step);
    op_e op;
    case (step)
      3'd0:    op = OpLoadX;
      3'd1:    op = OpLoadY;
      3'd2:    op = OpLoadZ;
      3'd3:    op = OpSetMask;
      3'd4:    op = OpSetTimer;
      default: op = OpBidCharge;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/bids22_ctrl_cnt.sv
// Loadable down-counter with zero / last flags.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val (a value of 0 is loaded as 1)
//   load_val     : value to load
//   dec          : decrement by one, stops at 0 (no wrap)
//   count        : current value
//   zero         : count == 0
//   last         : count == 1, i.e. this is the final counted cycle
module bids22_ctrl_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= (load_val == '0) ? W'(1) : load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign last  = (count_q == W'(1));

endmodule

// File: rtl/bids22_ctrl.sv
// Controller-side sequencer for the bids22 auctioneer.
// Accepts one auction configuration per cfg_valid/cfg_ready handshake, then issues the
// LoadX/LoadY/LoadZ/SetXYZmask/SetTimer/BidCharge opcodes, locks with the key, runs
// cfg_rounds bidding rounds (C_start high for cfg_round_len cycles each), reports each
// round's result on res_*, unlocks and pulses done. Faults stop the sequence and are
// reported on the sticky fault output until the next accepted configuration.
//   cfg_*               : configuration handshake and values from the host
//   ready, err          : auctioneer status, checked while the sequence runs
//   roundOver, maxBid,
//   X_win, Y_win, Z_win : auctioneer round result
//   C_op, C_data,
//   C_start             : registered controller interface to the auctioneer
//   res_*               : per-round result, valid during the res_valid pulse
//   done, fault         : completion pulse, sticky fault code
module bids22_ctrl
  import bids22_pkg::*;
#(
  parameter int unsigned RO_TIMEOUT = 16,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_x_value,
  input  logic [DATA_W-1:0] cfg_y_value,
  input  logic [DATA_W-1:0] cfg_z_value,
  input  logic [2:0]        cfg_mask,
  input  logic [DATA_W-1:0] cfg_timer,
  input  logic [DATA_W-1:0] cfg_cost,
  input  logic [DATA_W-1:0] cfg_key,
  input  logic [15:0]       cfg_round_len,
  input  logic [7:0]        cfg_rounds,
  input  logic              ready,
  input  logic [2:0]        err,
  input  logic              roundOver,
  input  logic [DATA_W-1:0] maxBid,
  input  logic              X_win,
  input  logic              Y_win,
  input  logic              Z_win,
  output logic [3:0]        C_op,
  output logic [DATA_W-1:0] C_data,
  output logic              C_start,
  output logic              res_valid,
  output logic [1:0]        res_winner,
  output logic [DATA_W-1:0] res_maxBid,
  output logic [7:0]        res_round,
  output logic              done,
  output logic [2:0]        fault
);

  // Latched configuration
  logic [DATA_W-1:0] x_q, y_q, z_q, timer_q, cost_q, key_q;
  logic [2:0]        mask_q;
  logic [15:0]       round_len_q;
  logic [7:0]        rounds_q;

  state_e            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [7:0]        round_q, round_d;
  op_e               c_op_q, c_op_d;
  logic [DATA_W-1:0] c_data_q, c_data_d;
  logic              c_start_q, c_start_d;
  logic              res_valid_q, res_valid_d;
  winner_e           res_winner_q, res_winner_d;
  logic [DATA_W-1:0] res_max_bid_q, res_max_bid_d;
  logic [7:0]        res_round_q, res_round_d;
  logic              done_q, done_d;
  logic [2:0]        fault_q, fault_d;
  logic              idle_q;

  logic              accept;
  logic              run_load, to_load;
  logic              run_zero, run_last, to_zero, to_last;
  logic [15:0]       run_count, to_count;
  logic [7:0]        rounds_eff;
  logic              more_rounds;
  logic [DATA_W-1:0] load_data;

  // Registered idle flag gated by the live ready input; 0 throughout reset.
  assign cfg_ready = idle_q && ready;
  assign accept    = cfg_valid && cfg_ready;

  assign rounds_eff  = (rounds_q == 8'd0) ? 8'd1 : rounds_q;
  assign more_rounds = ({1'b0, round_q} + 9'd1) < {1'b0, rounds_eff};

  always_comb begin
    load_data = cost_q;
    case (step_q)
      3'd0:    load_data = x_q;
      3'd1:    load_data = y_q;
      3'd2:    load_data = z_q;
      3'd3:    load_data = DATA_W'(mask_q);
      3'd4:    load_data = timer_q;
      default: load_data = cost_q;
    endcase
  end

  bids22_ctrl_cnt #(
    .W(16)
  ) u_run_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (run_load),
    .load_val(round_len_q),
    .dec     (state_q == StRun),
    .count   (run_count),
    .zero    (run_zero),
    .last    (run_last)
  );

  bids22_ctrl_cnt #(
    .W(16)
  ) u_to_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (to_load),
    .load_val(16'(RO_TIMEOUT)),
    .dec     (state_q == StWaitRo),
    .count   (to_count),
    .zero    (to_zero),
    .last    (to_last)
  );

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    round_d       = round_q;
    c_op_d        = OpNoOp;
    c_data_d      = '0;
    c_start_d     = 1'b0;
    res_valid_d   = 1'b0;
    res_winner_d  = res_winner_q;
    res_max_bid_d = res_max_bid_q;
    res_round_d   = res_round_q;
    done_d        = 1'b0;
    fault_d       = fault_q;
    run_load      = 1'b0;
    to_load       = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoad;
          step_d  = 3'd0;
          round_d = 8'd0;
          fault_d = 3'b000;
        end
      end
      StLoad: begin
        // step_q==0 is the cycle before the first op reaches the bus.
        if ((step_q != 3'd0) && (err != 3'b000)) begin
          state_d = StFault;
          fault_d = err;
        end else if (step_q == LoadLastStep) begin
          state_d  = StLock;
          c_op_d   = OpLock;
          c_data_d = key_q;
        end else begin
          c_op_d   = load_op(step_q);
          c_data_d = load_data;
          step_d   = step_q + 3'd1;
        end
      end
      StLock: begin
        if (err != 3'b000) begin
          state_d = StFault;
          fault_d = err;
        end else begin
          state_d   = StRun;
          c_start_d = 1'b1;
          run_load  = 1'b1;
        end
      end
      StRun: begin
        if (run_last || run_zero) begin
          state_d = StWaitRo;
          to_load = 1'b1;
        end else begin
          c_start_d = 1'b1;
        end
      end
      StWaitRo: begin
        if (roundOver) begin
          state_d     = StGap;
          res_valid_d = 1'b1;
          res_round_d = round_q;
          if (X_win) begin
            res_winner_d  = WinX;
            res_max_bid_d = maxBid;
          end else if (Y_win) begin
            res_winner_d  = WinY;
            res_max_bid_d = maxBid;
          end else if (Z_win) begin
            res_winner_d  = WinZ;
            res_max_bid_d = maxBid;
          end else begin
            res_winner_d  = WinNone;
            res_max_bid_d = '0;
          end
        end else if (to_last || to_zero) begin
          state_d = StFault;
          fault_d = FaultRoTimeout;
        end
      end
      StGap: begin
        if (more_rounds) begin
          round_d   = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
          state_d   = StRun;
          c_start_d = 1'b1;
          run_load  = 1'b1;
        end else begin
          state_d  = StUnlock;
          c_op_d   = OpUnlock;
          c_data_d = key_q;
        end
      end
      StUnlock: begin
        if (err != 3'b000) begin
          state_d = StFault;
          fault_d = err;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Losing the auctioneer anywhere in the sequence overrides everything above.
    if ((state_q != StIdle) && (state_q != StFault) && !ready) begin
      state_d   = StFault;
      fault_d   = FaultReadyLost;
      c_op_d    = OpNoOp;
      c_data_d  = '0;
      c_start_d = 1'b0;
      done_d    = 1'b0;
      run_load  = 1'b0;
      to_load   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      step_q        <= 3'd0;
      round_q       <= 8'd0;
      c_op_q        <= OpNoOp;
      c_data_q      <= '0;
      c_start_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_winner_q  <= WinNone;
      res_max_bid_q <= '0;
      res_round_q   <= 8'd0;
      done_q        <= 1'b0;
      fault_q       <= 3'b000;
      idle_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      round_q       <= round_d;
      c_op_q        <= c_op_d;
      c_data_q      <= c_data_d;
      c_start_q     <= c_start_d;
      res_valid_q   <= res_valid_d;
      res_winner_q  <= res_winner_d;
      res_max_bid_q <= res_max_bid_d;
      res_round_q   <= res_round_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
      idle_q        <= (state_d == StIdle);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      mask_q      <= 3'b000;
      timer_q     <= '0;
      cost_q      <= '0;
      key_q       <= '0;
      round_len_q <= 16'd0;
      rounds_q    <= 8'd0;
    end else if (accept) begin
      x_q         <= cfg_x_value;
      y_q         <= cfg_y_value;
      z_q         <= cfg_z_value;
      mask_q      <= cfg_mask;
      timer_q     <= cfg_timer;
      cost_q      <= cfg_cost;
      key_q       <= cfg_key;
      round_len_q <= cfg_round_len;
      rounds_q    <= cfg_rounds;
    end
  end

  assign C_op       = c_op_q;
  assign C_data     = c_data_q;
  assign C_start    = c_start_q;
  assign res_valid  = res_valid_q;
  assign res_winner = res_winner_q;
  assign res_maxBid = res_max_bid_q;
  assign res_round  = res_round_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_bids22_ctrl.sv
// Scoreboard bench for bids22_ctrl: stimulus pushes expected opcodes, C_start burst
// lengths and round results into queues; a monitor pops and compares whenever the DUT
// drives an opcode, ends a C_start burst or pulses res_valid. A small auctioneer stub
// answers each round with roundOver after a random delay.
module tb_bids22_ctrl;

  localparam int unsigned RO = 16;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] cfg_x_value = '0, cfg_y_value = '0, cfg_z_value = '0;
  logic [2:0]    cfg_mask = '0;
  logic [DW-1:0] cfg_timer = '0, cfg_cost = '0, cfg_key = '0;
  logic [15:0]   cfg_round_len = '0;
  logic [7:0]    cfg_rounds = '0;
  logic          ready = 1'b1;
  logic [2:0]    err = 3'b000;
  logic          roundOver = 1'b0;
  logic [DW-1:0] maxBid = '0;
  logic          X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;
  logic [3:0]    C_op;
  logic [DW-1:0] C_data;
  logic          C_start;
  logic          res_valid;
  logic [1:0]    res_winner;
  logic [DW-1:0] res_maxBid;
  logic [7:0]    res_round;
  logic          done;
  logic [2:0]    fault;

  always #5 clk = ~clk;

  bids22_ctrl #(
    .RO_TIMEOUT(RO),
    .DATA_W    (DW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_x_value  (cfg_x_value),
    .cfg_y_value  (cfg_y_value),
    .cfg_z_value  (cfg_z_value),
    .cfg_mask     (cfg_mask),
    .cfg_timer    (cfg_timer),
    .cfg_cost     (cfg_cost),
    .cfg_key      (cfg_key),
    .cfg_round_len(cfg_round_len),
    .cfg_rounds   (cfg_rounds),
    .ready        (ready),
    .err          (err),
    .roundOver    (roundOver),
    .maxBid       (maxBid),
    .X_win        (X_win),
    .Y_win        (Y_win),
    .Z_win        (Z_win),
    .C_op         (C_op),
    .C_data       (C_data),
    .C_start      (C_start),
    .res_valid    (res_valid),
    .res_winner   (res_winner),
    .res_maxBid   (res_maxBid),
    .res_round    (res_round),
    .done         (done),
    .fault        (fault)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] data;
  } op_t;

  typedef struct {
    logic [1:0]  w;
    logic [31:0] mb;
    logic [7:0]  r;
  } res_t;

  op_t  exp_ops[$];
  res_t exp_res[$];
  int   exp_bursts[$];

  int n_cmp = 0;
  int n_bad = 0;
  int stub_mode = 0;  // 0 random, 1 Y wins 50, 2 tie 0x1234, 3 silent
  int stub_round = 0;
  bit err_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT event against the head of its expectation queue.
  op_t  mon_op;
  res_t mon_res;
  int   run_len = 0;
  int   mon_burst;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run_len = 0;
      end else begin
        if (C_op != 4'd0) begin
          if (exp_ops.size() == 0) begin
            chk("op_unexpected", 32'(C_op), 32'd0);
          end else begin
            mon_op = exp_ops.pop_front();
            chk("op_code", 32'(C_op), 32'(mon_op.op));
            chk("op_data", C_data, mon_op.data);
          end
        end
        if (res_valid) begin
          if (exp_res.size() == 0) begin
            chk("res_unexpected", 32'(res_valid), 32'd0);
          end else begin
            mon_res = exp_res.pop_front();
            chk("res_winner", 32'(res_winner), 32'(mon_res.w));
            chk("res_maxBid", res_maxBid, mon_res.mb);
            chk("res_round", 32'(res_round), 32'(mon_res.r));
          end
        end
        if (C_start) begin
          run_len++;
        end else if (run_len > 0) begin
          if (exp_bursts.size() == 0) begin
            chk("burst_unexpected", 32'(run_len), 32'd0);
          end else begin
            mon_burst = exp_bursts.pop_front();
            chk("burst_len", 32'(run_len), 32'(mon_burst));
          end
          run_len = 0;
        end
      end
    end
  end

  // Auctioneer stub: answers each falling C_start with one roundOver pulse.
  initial begin
    bit          prev;
    int          d;
    logic [2:0]  flags;
    logic [31:0] mb;
    res_t        r;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b0;
      end else if (prev && !C_start && stub_mode != 3) begin
        d = (stub_mode == 0) ? int'($urandom_range(0, 10)) : 2;
        repeat (d) @(negedge clk);
        case (stub_mode)
          1: begin flags = 3'b010; mb = 32'd50; end
          2: begin flags = 3'b000; mb = 32'h1234; end
          default: begin flags = 3'($urandom_range(0, 7)); mb = $urandom; end
        endcase
        {X_win, Y_win, Z_win} = flags;
        maxBid    = mb;
        roundOver = 1'b1;
        r.w  = flags[2] ? 2'd1 : flags[1] ? 2'd2 : flags[0] ? 2'd3 : 2'd0;
        r.mb = (r.w == 2'd0) ? 32'd0 : mb;
        r.r  = 8'(stub_round);
        exp_res.push_back(r);
        stub_round++;
        @(negedge clk);
        roundOver = 1'b0;
        {X_win, Y_win, Z_win} = 3'b000;
        maxBid = '0;
        prev = C_start;
      end else begin
        prev = C_start;
      end
    end
  end

  // Error injector: reports err=4 while SetTimer is on the bus.
  initial begin
    forever begin
      @(negedge clk);
      err = (err_mode && C_op == 4'd7) ? 3'b100 : 3'b000;
    end
  end

  task automatic push_op(input logic [3:0] op, input logic [31:0] data);
    op_t o;
    o.op   = op;
    o.data = data;
    exp_ops.push_back(o);
  endtask

  task automatic issue_cfg(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                           input logic [2:0] mask, input logic [31:0] timer,
                           input logic [31:0] cost, input logic [31:0] key,
                           input logic [15:0] len, input logic [7:0] rounds);
    int n;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_ready_before_accept", 32'(cfg_ready), 32'd1);
    stub_round    = 0;
    cfg_x_value   = x;
    cfg_y_value   = y;
    cfg_z_value   = z;
    cfg_mask      = mask;
    cfg_timer     = timer;
    cfg_cost      = cost;
    cfg_key       = key;
    cfg_round_len = len;
    cfg_rounds    = rounds;
    cfg_valid     = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("fault_cleared_on_accept", 32'(fault), 32'd0);
    chk("cfg_ready_busy", 32'(cfg_ready), 32'd0);
  endtask

  task automatic run_case(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                          input logic [2:0] mask, input logic [31:0] timer,
                          input logic [31:0] cost, input logic [31:0] key,
                          input logic [15:0] len, input logic [7:0] rounds,
                          input int mode, input bit err_case);
    int len_eff, rounds_eff, n, exp_fault;
    bit timeout, got_done;
    len_eff    = (len == 16'd0) ? 1 : int'(len);
    rounds_eff = (rounds == 8'd0) ? 1 : int'(rounds);
    timeout    = (mode == 3);
    exp_fault  = err_case ? 4 : (timeout ? 7 : 0);
    stub_mode  = mode;
    err_mode   = err_case;

    push_op(4'd3, x);
    push_op(4'd4, y);
    push_op(4'd5, z);
    push_op(4'd6, {29'd0, mask});
    push_op(4'd7, timer);
    if (!err_case) begin
      push_op(4'd8, cost);
      push_op(4'd2, key);
      if (timeout) begin
        exp_bursts.push_back(len_eff);
      end else begin
        for (int i = 0; i < rounds_eff; i++) exp_bursts.push_back(len_eff);
        push_op(4'd1, key);
      end
    end

    issue_cfg(x, y, z, mask, timer, cost, key, len, rounds);

    got_done = 1'b0;
    if (timeout) begin
      n = 0;
      while (!C_start && n < 100) begin @(negedge clk); n++; end
      n = 0;
      while (C_start && n < 100000) begin @(negedge clk); n++; end
      n = 0;
      while (fault == 3'b000 && n < int'(RO) + 5) begin @(negedge clk); n++; end
      chk("timeout_cycles", 32'(n), 32'(RO));
      chk("cstart_low_at_fault", 32'(C_start), 32'd0);
    end else begin
      n = 0;
      while (n < 3000) begin
        @(negedge clk);
        n++;
        if (done) begin
          got_done = 1'b1;
          break;
        end
        if (fault != 3'b000) break;
      end
      if (got_done) begin
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
      end
    end
    chk("fault_code", 32'(fault), 32'(exp_fault));
    chk("done_seen", 32'(got_done), (exp_fault == 0) ? 32'd1 : 32'd0);
    if (err_case) chk("op_after_err", 32'(C_op), 32'd0);
    repeat (3) @(negedge clk);
    chk("cfg_ready_after", 32'(cfg_ready), 32'd1);
    chk("ops_left", 32'(exp_ops.size()), 32'd0);
    chk("res_left", 32'(exp_res.size()), 32'd0);
    chk("bursts_left", 32'(exp_bursts.size()), 32'd0);
    err_mode = 1'b0;
    exp_ops.delete();
    exp_res.delete();
    exp_bursts.delete();
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    chk("rst_C_op", 32'(C_op), 32'd0);
    chk("rst_C_start", 32'(C_start), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    ready = 1'b0;
    #1;
    chk("idle_cfg_ready_no_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    ready = 1'b1;

    // Directed cases
    run_case(32'd100, 32'd200, 32'd300, 3'd7, 32'd5, 32'd1, 32'hA5A5A5A5, 16'd4, 8'd1, 1, 1'b0);
    run_case(32'd11, 32'd22, 32'd33, 3'd5, 32'd9, 32'd2, 32'h1234_5678, 16'd3, 8'd3, 0, 1'b0);
    run_case(32'd1, 32'd2, 32'd3, 3'd1, 32'd4, 32'd5, 32'hDEAD_BEEF, 16'd2, 8'd1, 2, 1'b0);
    run_case(32'd7, 32'd8, 32'd9, 3'd2, 32'd3, 32'd1, 32'h0BAD_F00D, 16'd3, 8'd2, 3, 1'b0);
    run_case(32'd5, 32'd6, 32'd7, 3'd3, 32'd8, 32'd9, 32'hCAFE_0001, 16'd2, 8'd1, 0, 1'b1);
    run_case(32'd100, 32'd200, 32'd300, 3'd7, 32'd5, 32'd1, 32'hA5A5A5A5, 16'd0, 8'd0, 1, 1'b0);

    // Randomized configurations
    for (int k = 0; k < 6; k++) begin
      run_case($urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), $urandom, $urandom,
               $urandom, 16'($urandom_range(0, 5)), 8'($urandom_range(0, 4)), 0, 1'b0);
    end

    // Reset in the middle of a round
    stub_mode = 0;
    push_op(4'd3, 32'd1);
    push_op(4'd4, 32'd2);
    push_op(4'd5, 32'd3);
    push_op(4'd6, 32'd7);
    push_op(4'd7, 32'd4);
    push_op(4'd8, 32'd5);
    push_op(4'd2, 32'h5555_AAAA);
    issue_cfg(32'd1, 32'd2, 32'd3, 3'd7, 32'd4, 32'd5, 32'h5555_AAAA, 16'd20, 8'd2);
    n = 0;
    while (!C_start && n < 100) begin @(negedge clk); n++; end
    chk("reset_test_cstart_high", 32'(C_start), 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_C_start", 32'(C_start), 32'd0);
    chk("async_rst_C_op", 32'(C_op), 32'd0);
    chk("async_rst_res_valid", 32'(res_valid), 32'd0);
    chk("async_rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("reset_ops_left", 32'(exp_ops.size()), 32'd0);
    exp_ops.delete();
    exp_res.delete();
    exp_bursts.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("cfg_ready_after_reset", 32'(cfg_ready), 32'd1);

    run_case(32'd100, 32'd200, 32'd300, 3'd7, 32'd5, 32'd1, 32'hA5A5A5A5, 16'd4, 8'd2, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bids22_ctrl.md
Name: bids22_ctrl

Overview:
- Controller-side sequencer that drives the bids22 auctioneer's controller interface (C_op/C_data/C_start) on behalf of a host.
- One handshake accepts a full auction configuration; the block then:
  - issues the load/config opcodes,
  - locks with the key,
  - runs N bidding rounds and reports each round's result,
  - unlocks.
- Sits between host/testbench logic and bids22 and replaces hand-written opcode sequences.

Parameters:
- RO_TIMEOUT, 16, max cycles to wait for roundOver after C_start falls before declaring a fault.
- DATA_W, 32, width of C_data, config values and maxBid.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  host presents a configuration.
- cfg_ready  out  1  block idle, will accept the configuration.
- cfg_x_value, cfg_y_value, cfg_z_value  in  DATA_W each  initial balances, sent as LoadX/LoadY/LoadZ.
- cfg_mask  in  3  bidder enable mask {Z,Y,X}.
- cfg_timer  in  DATA_W  lockout timer value.
- cfg_cost  in  DATA_W  per-bid charge.
- cfg_key  in  DATA_W  lock/unlock key.
- cfg_round_len  in  16  cycles C_start is held high per round; 0 is treated as 1.
- cfg_rounds  in  8  number of rounds; 0 is treated as 1.
- ready  in  1  auctioneer ready.
- err  in  3  auctioneer controller error code.
- roundOver  in  1  auctioneer result strobe.
- maxBid  in  DATA_W  winning amount.
- X_win, Y_win, Z_win  in  1 each  winner flags.
- C_op  out  4  opcode to auctioneer.
- C_data  out  DATA_W  opcode operand.
- C_start  out  1  round active.
- res_valid  out  1  one-cycle pulse, result registers valid.
- res_winner  out  2  winner: 0 none/tie, 1 X, 2 Y, 3 Z.
- res_maxBid  out  DATA_W  captured maxBid; 0 when no winner.
- res_round  out  8  0-based index of the reported round.
- done  out  1  one-cycle pulse when the sequence completes with Unlock.
- fault  out  3  sticky fault code, cleared on next cfg accept.

Behaviour:
- Reset (asynchronous on reset_n low) forces:
  - FSM to IDLE;
  - C_op=NoOp(0), C_data=0, C_start=0;
  - cfg_ready=0, res_*=0, done=0, fault=0;
  - all counters to 0.
- The same values apply if reset asserts mid-sequence; there is no resume.
- cfg_ready=1 only in IDLE and only while ready=1.
- Config accepted on the edge where cfg_valid&&cfg_ready; all cfg_* are latched internally on that edge.
- States: IDLE, LOAD, LOCK, RUN, WAIT_RO, GAP, UNLOCK, DONE, FAULT.
- Outputs are registered. With acceptance at edge T, C_op/C_data change as follows:
  - LOAD: T+1..T+6, one op per cycle, in order LoadX(3), LoadY(4), LoadZ(5), SetXYZmask(6, data={29'b0,mask}), SetTimer(7), BidCharge(8).
  - LOCK: T+7, Lock(2) with data=key.
  - RUN: from T+8, C_op=NoOp and C_start=1 for exactly round_len cycles; the down-counter is loaded with round_len.
- WAIT_RO:
  - C_start=0; timeout counter loaded with RO_TIMEOUT.
  - On a cycle with roundOver=1, capture maxBid, X/Y/Z_win and the round index.
  - Winner encoding: X_win gives 1, else Y_win 2, else Z_win 3, else 0 with res_maxBid=0.
  - res_valid pulses on the next cycle.
  - Counter reaches 0 with no roundOver: fault=3'b111, go to FAULT.
- GAP: one NoOp cycle, then:
  - if rounds remain, increment the round index and go to RUN;
  - otherwise go to UNLOCK.
- UNLOCK: one cycle Unlock(1) with data=key, then DONE.
- DONE: done pulses for one cycle, then IDLE.
- Error checking:
  - err is sampled in every LOAD/LOCK/UNLOCK cycle in which the op is driven.
  - Any nonzero err latches fault=err and goes to FAULT.
- ready=0 in any state other than IDLE: fault=3'b110, go to FAULT.
- FAULT:
  - drives NoOp, C_start=0;
  - returns to IDLE after one cycle; fault stays held until the next accept.
- cfg_valid while busy is ignored (cfg_ready=0); no queueing.
- Counters:
  - round_len counter is 16-bit, no wrap; a loaded value of 0 is forced to 1.
  - Round index saturates at 255.
  - Arithmetic is unsigned.

Decomposition:
- bids22_pkg holds:
  - opcode enum (NoOp..BidCharge, 4-bit);
  - winner encoding;
  - fault code constants (3'b110 READY_LOST, 3'b111 RO_TIMEOUT);
  - controller state typedef.
- One sub-module, bids22_ctrl_cnt: loadable down-counter with zero flag, instantiated twice (round length, roundOver timeout).

Test Plan:
- Basic sequence:
  - Stimulus: x=100, y=200, z=300, mask=7, timer=5, cost=1, key=0xA5A5A5A5, round_len=4, rounds=1.
  - Response: ops 3,4,5,6,7,8,2 on consecutive cycles; C_start high exactly 4 cycles.
  - Auctioneer returns roundOver with Y_win, maxBid=50 → res_winner=2, res_maxBid=50, res_round=0.
  - Then Unlock with data=0xA5A5A5A5, then done pulse.
- Multi-round: rounds=3.
  - Three C_start bursts, each separated by a roundOver plus a one-cycle GAP.
  - res_round=0,1,2; a single Unlock at the end.
- Tie/no winner:
  - roundOver with all win flags 0 and maxBid=0x1234 → res_winner=0, res_maxBid=0.
- Timeout:
  - roundOver never asserts → fault=3'b111 exactly RO_TIMEOUT cycles after C_start falls.
  - C_start stays 0; no Unlock issued; cfg_ready returns.
- Error response:
  - err=3'b100 during SetTimer → fault=4, no Lock issued, next op NoOp.
  - fault cleared on the next config accept.
- Reset mid-RUN:
  - reset_n low while C_start=1 → C_start=0, C_op=0, res_valid=0 immediately (asynchronous).
  - After release, cfg_ready=1 when ready=1.
